// File: rtl/verify_sequencer_pkg.sv
// Shared constants, state encoding and section-size helpers for the signature verify sequencer.
// Section sizes are byte counts per security level, rounded up to whole W-bit words.
package verify_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_RHO,
        S_C,
        S_Z,
        S_T1,
        S_MLEN,
        S_MSG,
        S_H,
        S_RESULT,
        S_HOLD
    } state_t;

    localparam int unsigned SEED_BYTES = 32;

    function automatic int unsigned words_of(input int unsigned bytes, input int unsigned w);
        return (bytes * 8 + w - 1) / w;
    endfunction

    function automatic int unsigned seed_words(input int sec_level, input int unsigned w);
        if (sec_level < 0) return words_of(SEED_BYTES, w);
        return words_of(SEED_BYTES, w);
    endfunction

    function automatic int unsigned z_words(input int sec_level, input int unsigned w);
        case (sec_level)
            2:       return words_of(2304, w);
            3:       return words_of(3200, w);
            default: return words_of(4480, w);
        endcase
    endfunction

    function automatic int unsigned t1_words(input int sec_level, input int unsigned w);
        case (sec_level)
            2:       return words_of(1280, w);
            3:       return words_of(1920, w);
            default: return words_of(2560, w);
        endcase
    endfunction

    // Hint vector is omega + K bytes.
    function automatic int unsigned h_words(input int sec_level, input int unsigned w);
        case (sec_level)
            2:       return words_of(84, w);
            3:       return words_of(61, w);
            default: return words_of(83, w);
        endcase
    endfunction

endpackage

// File: rtl/verify_msg_len.sv
// Message word count: max(1, ceil(mlen*8/W)) for a byte length mlen.
// Latency: combinational. Backpressure: none.
module verify_msg_len #(
    parameter int W = 64
) (
    input  logic [31:0] mlen,
    output logic [31:0] msg_words
);

    logic [35:0] bits_up;
    logic [35:0] quot;

    assign bits_up   = {1'b0, mlen, 3'b000} + 36'(W - 1);
    assign quot      = bits_up / 36'(W);
    assign msg_words = (quot == 36'd0) ? 32'd1 : quot[31:0];

endmodule

// File: rtl/verify_sequencer.sv
// Sequences host words into the signature core section by section, then returns the verdict.
// Latency: zero-cycle pass-through while loading; one START cycle; result held until res_ready.
// Backpressure: host_ready follows core_ready_i in load states; optional cycle_cnt under VERIFY_SEQ_CYCLE_CNT_EN.
module verify_sequencer
    import verify_sequencer_pkg::*;
#(
    parameter int HIGH_PERF = 1,
    parameter int SEC_LEVEL = 2,
    parameter int W         = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         host_start,
    input  logic         host_valid,
    output logic         host_ready,
    input  logic [W-1:0] host_data,
    output logic         core_start,
    output logic         core_valid_i,
    input  logic         core_ready_i,
    output logic [W-1:0] core_data_i,
    input  logic         core_valid_o,
    output logic         core_ready_o,
    input  logic [W-1:0] core_data_o,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_ok
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
    ,output logic [31:0] cycle_cnt
`endif
);

    localparam int unsigned SEED_N = seed_words(SEC_LEVEL, W);
    localparam int unsigned Z_N    = z_words(SEC_LEVEL, W);
    localparam int unsigned T1_N   = t1_words(SEC_LEVEL, W);
    localparam int unsigned H_N    = h_words(SEC_LEVEL, W);

    state_t      state_q, state_d, nxt_sec;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] mlen_q, mlen_d;
    logic        res_ok_q, res_ok_d;
    logic [31:0] sec_len, msg_words;
    logic        load, fire, last;
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;
`endif

    verify_msg_len #(.W(W)) u_msg_len (
        .mlen      (mlen_q),
        .msg_words (msg_words)
    );

    always_comb begin
        sec_len = 32'd1;
        load    = 1'b1;
        case (state_q)
            S_RHO, S_C: sec_len = SEED_N;
            S_Z:        sec_len = Z_N;
            S_T1:       sec_len = T1_N;
            S_H:        sec_len = H_N;
            S_MLEN:     sec_len = 32'd1;
            S_MSG:      sec_len = msg_words;
            default:    load    = 1'b0;
        endcase
    end

    // The two core variants consume the same sections in a different order.
    always_comb begin
        nxt_sec = S_RESULT;
        if (HIGH_PERF != 0) begin
            case (state_q)
                S_RHO:   nxt_sec = S_C;
                S_C:     nxt_sec = S_Z;
                S_Z:     nxt_sec = S_T1;
                S_T1:    nxt_sec = S_MLEN;
                S_MLEN:  nxt_sec = S_MSG;
                S_MSG:   nxt_sec = S_H;
                default: nxt_sec = S_RESULT;
            endcase
        end else begin
            case (state_q)
                S_RHO:   nxt_sec = S_T1;
                S_T1:    nxt_sec = S_C;
                S_C:     nxt_sec = S_Z;
                S_Z:     nxt_sec = S_H;
                S_H:     nxt_sec = S_MLEN;
                S_MLEN:  nxt_sec = S_MSG;
                default: nxt_sec = S_RESULT;
            endcase
        end
    end

    assign fire = load && host_valid && core_ready_i;
    assign last = fire && (cnt_q == sec_len - 32'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mlen_d   = mlen_q;
        res_ok_d = res_ok_q;
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
        cyc_d    = cyc_q;
        if (state_q != S_IDLE && state_q != S_HOLD) cyc_d = cyc_q + 32'd1;
`endif
        case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    state_d = S_START;
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
                    cyc_d   = 32'd0;
`endif
                end
            end
            S_START: state_d = S_RHO;
            S_RESULT: begin
                if (core_valid_o) begin
                    res_ok_d = (core_data_o != {{(W-1){1'b0}}, 1'b1});
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: begin
                if (fire) begin
                    if (state_q == S_MLEN) mlen_d = host_data[31:0];
                    if (last) begin
                        cnt_d   = 32'd0;
                        state_d = nxt_sec;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 32'd0;
            mlen_q   <= 32'd0;
            res_ok_q <= 1'b0;
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
            cyc_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mlen_q   <= mlen_d;
            res_ok_q <= res_ok_d;
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
            cyc_q    <= cyc_d;
`endif
        end
    end

    assign core_start   = (state_q == S_START);
    assign core_valid_i = load && host_valid;
    assign host_ready   = load && core_ready_i;
    assign core_data_i  = load ? host_data : '0;
    assign core_ready_o = (state_q == S_RESULT);
    assign res_valid    = (state_q == S_HOLD);
    assign res_ok       = res_valid && res_ok_q;
    assign busy         = (state_q != S_IDLE);
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
    assign cycle_cnt    = cyc_q;
`endif

endmodule

// File: tb/tb_verify_sequencer.sv
// Directed bench for verify_sequencer: instance 0 is the high-performance order, instance 1 the low-area order.
`timescale 1ns/1ps
module tb_verify_sequencer;

    localparam int W = 64;
    localparam int RHO = 0, SC = 1, SZ = 2, ST1 = 3, SMLEN = 4, SMSG = 5, SH = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         hs_start[2], h_vld[2], h_rdy[2], c_start[2], c_vld_i[2], c_rdy_i[2];
    logic         c_vld_o[2], c_rdy_o[2], busy[2], r_vld[2], r_rdy[2], r_ok[2];
    logic [W-1:0] h_dat[2], c_dat_i[2], c_dat_o[2];
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
    logic [31:0]  cyc_cnt[2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        verify_sequencer #(.HIGH_PERF(g == 0 ? 1 : 0), .SEC_LEVEL(2), .W(W)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .host_start   (hs_start[g]),
            .host_valid   (h_vld[g]),
            .host_ready   (h_rdy[g]),
            .host_data    (h_dat[g]),
            .core_start   (c_start[g]),
            .core_valid_i (c_vld_i[g]),
            .core_ready_i (c_rdy_i[g]),
            .core_data_i  (c_dat_i[g]),
            .core_valid_o (c_vld_o[g]),
            .core_ready_o (c_rdy_o[g]),
            .core_data_o  (c_dat_o[g]),
            .busy         (busy[g]),
            .res_valid    (r_vld[g]),
            .res_ready    (r_rdy[g]),
            .res_ok       (r_ok[g])
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
            ,.cycle_cnt   (cyc_cnt[g])
`endif
        );
    end

    typedef struct {
        int          sel;
        logic [31:0] mlen;
        int          msgw;
        bit          gaps;
        logic [63:0] cres;
        bit          ok;
        int          hold;
        bit          start_busy;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cur_job = 0;
    logic [63:0] exp_q[$];
    int ord_hp[7] = '{RHO, SC, SZ, ST1, SMLEN, SMSG, SH};
    int ord_la[7] = '{RHO, ST1, SC, SZ, SH, SMLEN, SMSG};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL job%0d %s: got %0h expected %0h", cur_job, name, act, exp);
        end
    endtask

    // Section sizes for SEC_LEVEL 2, W 64: 32 B seed, 2304 B z, 1280 B t1, 84 B hint.
    function automatic int sec_len(input int s, input int msgw);
        case (s)
            RHO, SC: return 4;
            SZ:      return 288;
            ST1:     return 160;
            SMLEN:   return 1;
            SMSG:    return msgw;
            default: return 11;
        endcase
    endfunction

    // Non-MLEN words carry 0x1000 in the low half so a misaligned MLEN capture is loud.
    task automatic build(input int sel, input logic [31:0] mlen, input int msgw);
        int s;
        exp_q.delete();
        for (int k = 0; k < 7; k++) begin
            s = (sel == 0) ? ord_hp[k] : ord_la[k];
            for (int i = 0; i < sec_len(s, msgw); i++)
                exp_q.push_back({8'(s), 24'(i), (s == SMLEN) ? mlen : 32'h0000_1000});
        end
    endtask

    task automatic start_job(input int s);
        @(posedge clk); #1;
        hs_start[s] = 1'b1; h_vld[s] = 1'b0; c_rdy_i[s] = 1'b1; c_vld_o[s] = 1'b0; r_rdy[s] = 1'b0;
        @(negedge clk);
        chk("busy_before_start", 64'(busy[s]), 64'd0);
        @(posedge clk); #1;
        hs_start[s] = 1'b0;
        @(negedge clk);
        chk("core_start", 64'(c_start[s]), 64'd1);
        chk("busy_in_start", 64'(busy[s]), 64'd1);
    endtask

    task automatic run_job(input vec_t v);
        int s, idx, cyc, errs, budget, tot;
        bit hv, cr;
        s = v.sel; idx = 0; errs = 0;
        build(s, v.mlen, v.msgw);
        tot = exp_q.size();
        start_job(s);
        cyc = 1;
        budget = 20 * tot;
        while (idx < tot && budget > 0) begin
            @(posedge clk); #1;
            hv = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cr = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            h_vld[s] = hv; h_dat[s] = exp_q[idx]; c_rdy_i[s] = cr;
            hs_start[s] = v.start_busy && (idx == 20);
            @(negedge clk);
            cyc++; budget--;
            if (c_start[s] || c_rdy_o[s] || r_vld[s]) errs++;
            if (h_rdy[s] !== cr || c_vld_i[s] !== hv || c_dat_i[s] !== exp_q[idx]) errs++;
            if (hv && cr) idx++;
        end
        chk("words_accepted", 64'(idx), 64'(tot));
        chk("load_phase_errors", 64'(errs), 64'd0);

        @(posedge clk); #1;
        h_vld[s] = 1'b0; hs_start[s] = 1'b0; c_rdy_i[s] = 1'b1;
        @(negedge clk);
        cyc++;
        chk("result_core_ready_o", 64'(c_rdy_o[s]), 64'd1);
        chk("result_host_ready", 64'(h_rdy[s]), 64'd0);
        @(posedge clk); #1;
        c_vld_o[s] = 1'b1; c_dat_o[s] = v.cres;
        @(negedge clk);
        cyc++;
        chk("capture_core_ready_o", 64'(c_rdy_o[s]), 64'd1);
        @(posedge clk); #1;
        c_vld_o[s] = 1'b0; c_dat_o[s] = v.cres ^ 64'd1;
        @(negedge clk);
        chk("res_valid", 64'(r_vld[s]), 64'd1);
        chk("res_ok", 64'(r_ok[s]), 64'(v.ok));
        chk("core_ready_o_dropped", 64'(c_rdy_o[s]), 64'd0);
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
        chk("cycle_cnt", 64'(cyc_cnt[s]), 64'(cyc));
`endif
        errs = 0;
        for (int k = 0; k < v.hold; k++) begin
            @(posedge clk); #1;
            r_rdy[s] = 1'b0;
            @(negedge clk);
            if (!r_vld[s] || !busy[s] || r_ok[s] !== v.ok) errs++;
        end
        if (v.hold > 0) chk("hold_stable", 64'(errs), 64'd0);
        @(posedge clk); #1;
        r_rdy[s] = 1'b1;
        @(negedge clk);
        chk("res_valid_at_ready", 64'(r_vld[s]), 64'd1);
        @(posedge clk); #1;
        r_rdy[s] = 1'b0;
        @(negedge clk);
        chk("busy_after_consume", 64'(busy[s]), 64'd0);
        chk("res_valid_after_consume", 64'(r_vld[s]), 64'd0);
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
        chk("cycle_cnt_held_idle", 64'(cyc_cnt[s]), 64'(cyc));
`endif
    endtask

    task automatic chk_outputs_zero(input int s, input string name);
        chk(name, 64'({busy[s], c_start[s], h_rdy[s], c_vld_i[s], c_rdy_o[s], r_vld[s], r_ok[s]}), 64'd0);
        chk({name, "_core_data_i"}, c_dat_i[s], 64'd0);
`ifdef VERIFY_SEQ_CYCLE_CNT_EN
        chk({name, "_cycle_cnt"}, 64'(cyc_cnt[s]), 64'd0);
`endif
    endtask

    vec_t vt[6];

    initial begin
        // mlen 33 -> 264 bits -> 5 words; 0 -> 1; 8 -> 1; 9 -> 2; 100 -> 800 bits -> 13.
        vt[0] = '{sel: 0, mlen: 32'd33,  msgw: 5,  gaps: 1'b0, cres: 64'd0, ok: 1'b1, hold: 0,  start_busy: 1'b0};
        vt[1] = '{sel: 0, mlen: 32'd0,   msgw: 1,  gaps: 1'b1, cres: 64'd0, ok: 1'b1, hold: 0,  start_busy: 1'b0};
        vt[2] = '{sel: 0, mlen: 32'd8,   msgw: 1,  gaps: 1'b0, cres: 64'd2, ok: 1'b1, hold: 2,  start_busy: 1'b0};
        vt[3] = '{sel: 0, mlen: 32'd9,   msgw: 2,  gaps: 1'b1, cres: 64'd1, ok: 1'b0, hold: 10, start_busy: 1'b0};
        vt[4] = '{sel: 1, mlen: 32'd33,  msgw: 5,  gaps: 1'b1, cres: 64'd0, ok: 1'b1, hold: 0,  start_busy: 1'b1};
        vt[5] = '{sel: 1, mlen: 32'd100, msgw: 13, gaps: 1'b0, cres: 64'd1, ok: 1'b0, hold: 3,  start_busy: 1'b1};

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            hs_start[s] = 1'b0; h_vld[s] = 1'b0; h_dat[s] = '0; c_rdy_i[s] = 1'b0;
            c_vld_o[s] = 1'b0; c_dat_o[s] = '0; r_rdy[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero(0, "reset_hp");
        chk_outputs_zero(1, "reset_la");

        for (int j = 0; j < 6; j++) begin
            cur_job = j;
            run_job(vt[j]);
        end

        // Reset in the middle of the z section, then a fresh job must run cleanly.
        cur_job = 6;
        build(0, 32'd33, 5);
        start_job(0);
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            h_vld[0] = 1'b1; h_dat[0] = exp_q[i]; c_rdy_i[0] = 1'b1;
        end
        @(posedge clk); #1;
        h_dat[0] = exp_q[18]; rst = 1'b1;
        @(negedge clk);
        chk("mid_z_host_ready", 64'(h_rdy[0]), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero(0, "reset_mid_z");
        @(posedge clk); #1;
        h_vld[0] = 1'b0;
        cur_job = 7;
        run_job(vt[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
